// File: rtl/spi_mstr_mss.sv
// SPI master (mode 0) with integrated one-hot active-low slave-select decode.
// Each frame carries its own slave index and bit length; all outputs are registered.
module spi_mstr_mss #(
    parameter int unsigned NUM_SS   = 5,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned SCLK_DIV = 16,
    localparam int unsigned SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
    localparam int unsigned LEN_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] cmd,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] ss_n,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned H     = SCLK_DIV / 2;
    localparam int unsigned DIV_W = (H > 1) ? $clog2(H) : 1;

    localparam logic [DIV_W-1:0] DivLast  = DIV_W'(H - 1);
    localparam logic [SEL_W:0]   NumSs    = (SEL_W + 1)'(NUM_SS);
    localparam logic [LEN_W-1:0] DataWLen = LEN_W'(DATA_W);

    typedef enum logic [1:0] {
        StIdle,
        StFront,
        StShift,
        StBack
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                sclk_q, sclk_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                req_valid;
    logic                div_last;

    assign req_valid = ({1'b0, ss_sel} < NumSs) && (len != '0) && (len <= DataWLen);
    assign div_last  = (div_cnt_q == DivLast);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        ss_n_d    = ss_n_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (wrt) begin
                    if (req_valid) begin
                        // Left-align so the first bit sits at the MSB and zeros trail.
                        tx_d      = cmd << (DataWLen - len);
                        rx_d      = '0;
                        bit_cnt_d = len;
                        div_cnt_d = '0;
                        ss_n_d    = ~(NUM_SS'(1) << ss_sel);
                        busy_d    = 1'b1;
                        state_d   = StFront;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFront: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    rx_d      = {rx_q[DATA_W-2:0], MISO};
                    state_d   = StShift;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            StShift: begin
                if (!div_last) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        tx_d      = {tx_q[DATA_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - LEN_W'(1);
                    end else if (bit_cnt_q == '0) begin
                        // Final low half-period done; hold select for the trailing guard.
                        state_d = StBack;
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[DATA_W-2:0], MISO};
                    end
                end
            end
            StBack: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    ss_n_d    = '1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rd_data_d = rx_q;
                    state_d   = StIdle;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
            ss_n_q    <= '1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
            ss_n_q    <= ss_n_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // tx drains to zero after a frame and is cleared on reset, so its MSB is MOSI directly.
    assign MOSI    = tx_q[DATA_W-1];
    assign SCLK    = sclk_q;
    assign ss_n    = ss_n_q;
    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: doc/spi_mstr_mss.md
# spi_mstr_mss

Parametrised SPI master with a built-in one-hot slave-select decoder. It replaces the single-SS SPI master plus external SS-steering logic in the DSO digital top level. Each transaction carries a slave index and a bit length (1..DATA_W), and the block drives exactly one active-low slave select for the frame's duration. The block sits between the command/core logic and the AFE gain pots, the trigger pot and the calibration EEPROM.

## Interface

**Parameters**
- NUM_SS, default 5: number of slave-select outputs (≥1).
- DATA_W, default 24: maximum frame length and width of the cmd / rd_data ports (≥2).
- SCLK_DIV, default 16: clk cycles per SCLK period; even, ≥4. H = SCLK_DIV/2.

**Ports (clock and reset first)**
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous and active-low.
- wrt  in  1  start request, sampled every clk.
- ss_sel  in  max(1,$clog2(NUM_SS))  target slave index, sampled with wrt.
- len  in  $clog2(DATA_W+1)  frame length in bits, sampled with wrt.
- cmd  in  DATA_W  transmit data, right-aligned; cmd[len-1] is sent first.
- MISO  in  1  serial data from slave.
- SCLK  out  1  SPI clock, mode 0 (idle low).
- MOSI  out  1  serial data to slave.
- ss_n  out  NUM_SS  active-low selects, at most one low at a time.
- rd_data  out  DATA_W  received data, right-aligned, upper bits zero.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of frame.
- err  out  1  one-cycle pulse when a request is rejected.

## Operation

- **States:** IDLE, FRONT, SHIFT, BACK, then IDLE again.
- **IDLE, wrt=1, valid request** (ss_sel < NUM_SS and 1 ≤ len ≤ DATA_W):
  - Latch sel.
  - Load tx shift register with cmd << (DATA_W-len), i.e. left-aligned, with zeros below.
  - Clear rx register; load bit counter with len; go to FRONT.
- **IDLE, wrt=1, invalid request:** stay in IDLE. Next cycle err=1 for one cycle. No ss_n activity and no done.
- **wrt while busy=1:** ignored, no err.
- **FRONT:** H cycles. ss_n[sel]=0, SCLK=0, MOSI = tx MSB.
- **SHIFT:** for each bit:
  - SCLK high for H cycles. On the clk edge that raises SCLK, rx <= {rx[DATA_W-2:0], MISO}.
  - Then SCLK low for H cycles. On the clk edge that lowers SCLK, tx shifts left and a zero enters.
  - After len falling edges, go to BACK.
- **BACK:** H cycles. SCLK=0; ss_n[sel] stays low; MOSI=0, since the left-align guarantees zeros remain.
- **End of BACK:**
  - ss_n goes all ones.
  - rd_data <= rx. Only the low len bits can be non-zero, because rx was cleared.
  - done=1 for one cycle; busy=0; return to IDLE.
- **Idle drive:** in IDLE, MOSI=0, SCLK=0, ss_n all ones.
- rd_data holds its value until the next done.
- **Asynchronous reset, including mid-frame:**
  - Immediately: SCLK=0, MOSI=0, ss_n all ones, busy=0, done=0, err=0, rd_data=0.
  - State returns to IDLE; counters clear.
  - No done is produced for the aborted frame.

## Timing

- Define the wrt-accept cycle as cycle 0.
- **Selects:**
  - ss_n[sel] is low in cycles 1 through (len+1)*SCLK_DIV inclusive.
  - busy is high over the same span.
- **Clock edges:**
  - First SCLK rise at cycle H+1.
  - Bit k (0-based) rises at H+1+2kH and falls at 1+2H(k+1).
- **Completion:** done pulses in cycle (len+1)*SCLK_DIV+1; ss_n is all ones and busy=0 in that cycle.
- **Back-to-back:** wrt asserted in the done cycle is accepted, so the next ss_n falls the following cycle.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **Reject:** err pulses in cycle 1 after a rejected wrt in cycle 0.

## Test plan

1. Loopback (MISO=MOSI), NUM_SS=5, DATA_W=24, SCLK_DIV=16, ss_sel=2, len=16, cmd=0x00A5C3:
   - ss_n=5'b11011 for cycles 1..272; done at cycle 273.
   - rd_data=0x00A5C3; exactly 16 SCLK rises.
2. len=8, cmd=0x0012AB, MISO tied 1, ss_sel=0:
   - MOSI serialises 1010_1011 MSB-first; 8 SCLK pulses.
   - rd_data=0x0000FF; done at cycle 145.
3. Invalid requests:
   - ss_sel=5 → err at cycle 1; ss_n stays 5'b11111; no done.
   - Repeat with len=0, then len=25: same result.
4. Busy handling:
   - wrt with different ss_sel during a busy frame is ignored: ss_n pattern unchanged, single done.
   - wrt in the done cycle is accepted: new ss_n low at done+1.
5. Mid-frame reset: assert rst_n=0 during bit 5 of a 24-bit frame.
   - Same cycle: ss_n=5'b11111, SCLK=0, MOSI=0, rd_data=0, busy=0.
   - After release: no done until a new wrt.
6. Full-width frame, len=24, cmd=0xFFFFFF, MISO=0:
   - rd_data=0x000000; done at cycle 401.
   - MOSI=0 during BACK and after.
